// File: rtl/btb_assoc.sv
// rtl/btb_assoc.sv - set-associative BTB with direction counters, round-robin replacement and sequential flush
module btb_assoc #(
   parameter int SETS     = 32,
   parameter int WAYS     = 2,
   parameter int TAG_BITS = 20,
   parameter int CNT_BITS = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_query,
   input  logic        is_jump,
   output logic        hit,
   output logic        pred_taken,
   output logic [31:0] target_addr,
   input  logic        update_en,
   input  logic [31:0] pc_update,
   input  logic [31:0] target_addr_update,
   input  logic        taken_update,
   input  logic        flush_req,
   output logic        flush_busy
);
   localparam int IDX   = $clog2(SETS);
   localparam int PTR_W = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;
   localparam logic [CNT_BITS-1:0] CNT_INIT = CNT_BITS'(1 << (CNT_BITS - 1));

   typedef enum logic {S_IDLE, S_FLUSH} state_t;

   logic                valid_q [SETS][WAYS];
   logic [TAG_BITS-1:0] tag_q   [SETS][WAYS];
   logic [31:0]         tgt_q   [SETS][WAYS];
   logic [CNT_BITS-1:0] ctr_q   [SETS][WAYS];
   logic [PTR_W-1:0]    ptr_q   [SETS];

   state_t         state_q, state_d;
   logic [IDX-1:0] fcnt_q, fcnt_d;

   logic [IDX-1:0]      q_idx, u_idx;
   logic [TAG_BITS-1:0] q_tag, u_tag;
   logic                q_match, u_match, free_found, do_upd;
   logic [PTR_W-1:0]    q_way, u_way, free_way, victim, wr_way, ptr_next;
   logic [CNT_BITS-1:0] ctr_next;

   assign flush_busy = (state_q == S_FLUSH);

   // Combinational lookup: scan every way of the queried set for a valid tag match
   always_comb begin
      q_idx   = pc_query[IDX+1:2];
      q_tag   = pc_query[31 -: TAG_BITS];
      q_match = 1'b0;
      q_way   = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (valid_q[q_idx][w] && (tag_q[q_idx][w] == q_tag)) begin
            q_match = 1'b1;
            q_way   = PTR_W'(w);
         end
      end
      hit         = q_match && is_jump && (state_q == S_IDLE);
      pred_taken  = hit ? ctr_q[q_idx][q_way][CNT_BITS-1] : 1'b0;
      target_addr = hit ? tgt_q[q_idx][q_way] : 32'h0;
   end

   // Update decode: find the matching way, the lowest free way and the replacement victim
   always_comb begin
      u_idx      = pc_update[IDX+1:2];
      u_tag      = pc_update[31 -: TAG_BITS];
      u_match    = 1'b0;
      u_way      = '0;
      free_found = 1'b0;
      free_way   = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (valid_q[u_idx][w] && (tag_q[u_idx][w] == u_tag)) begin
            u_match = 1'b1;
            u_way   = PTR_W'(w);
         end
      end
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!valid_q[u_idx][w]) begin
            free_found = 1'b1;
            free_way   = PTR_W'(w);
         end
      end
      victim   = free_found ? free_way : ptr_q[u_idx];
      wr_way   = u_match ? u_way : victim;
      ptr_next = (ptr_q[u_idx] == PTR_W'(WAYS - 1)) ? '0 : ptr_q[u_idx] + 1'b1;
      ctr_next = ctr_q[u_idx][u_way];
      if (taken_update) begin
         if (ctr_q[u_idx][u_way] != CNT_MAX) ctr_next = ctr_q[u_idx][u_way] + 1'b1;
      end else begin
         if (ctr_q[u_idx][u_way] != '0) ctr_next = ctr_q[u_idx][u_way] - 1'b1;
      end
      // Updates are dropped while flushing and in the cycle a flush is accepted
      do_upd = update_en && (state_q == S_IDLE) && !flush_req;
   end

   // Valid bits, counters and victim pointers: reset, flush clearing, hit training and allocation
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int s = 0; s < SETS; s++) begin
            ptr_q[s] <= '0;
            for (int w = 0; w < WAYS; w++) begin
               valid_q[s][w] <= 1'b0;
               ctr_q[s][w]   <= '0;
            end
         end
      end else if (state_q == S_FLUSH) begin
         ptr_q[fcnt_q] <= '0;
         for (int w = 0; w < WAYS; w++) valid_q[fcnt_q][w] <= 1'b0;
      end else if (do_upd) begin
         if (u_match) begin
            ctr_q[u_idx][u_way] <= ctr_next;
         end else if (taken_update) begin
            valid_q[u_idx][victim] <= 1'b1;
            ctr_q[u_idx][victim]   <= CNT_INIT;
            if (!free_found) ptr_q[u_idx] <= ptr_next;
         end
      end
   end

   // Tag and target payload: written on hit or allocation, never reset
   always_ff @(posedge clk) begin
      if (do_upd && (u_match || taken_update)) begin
         tag_q[u_idx][wr_way] <= u_tag;
         tgt_q[u_idx][wr_way] <= target_addr_update;
      end
   end

   // Flush FSM state register and set counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         fcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         fcnt_q  <= fcnt_d;
      end
   end

   // Flush FSM next state: walk every set once, then return to IDLE
   always_comb begin
      state_d = state_q;
      fcnt_d  = fcnt_q;
      case (state_q)
         S_IDLE: begin
            if (flush_req) begin
               state_d = S_FLUSH;
               fcnt_d  = '0;
            end
         end
         S_FLUSH: begin
            fcnt_d = fcnt_q + 1'b1;
            if (fcnt_q == IDX'(SETS - 1)) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end
endmodule

// File: tb/tb_btb_assoc.sv
// tb/tb_btb_assoc.sv - directed self-checking bench for btb_assoc
module tb_btb_assoc;
   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_query;
   logic        is_jump;
   logic        hit;
   logic        pred_taken;
   logic [31:0] target_addr;
   logic        update_en;
   logic [31:0] pc_update;
   logic [31:0] target_addr_update;
   logic        taken_update;
   logic        flush_req;
   logic        flush_busy;

   int checks = 0;
   int errors = 0;

   btb_assoc dut (
      .clk(clk), .rst(rst),
      .pc_query(pc_query), .is_jump(is_jump),
      .hit(hit), .pred_taken(pred_taken), .target_addr(target_addr),
      .update_en(update_en), .pc_update(pc_update),
      .target_addr_update(target_addr_update), .taken_update(taken_update),
      .flush_req(flush_req), .flush_busy(flush_busy)
   );

   always #5 clk = ~clk;

   task automatic do_update(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
      update_en = 1'b1; pc_update = pc; target_addr_update = tgt; taken_update = tk;
      @(posedge clk); #1;
      update_en = 1'b0;
   endtask

   task automatic query(input logic [31:0] pc, input logic j);
      pc_query = pc; is_jump = j;
      #1;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      #2;
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; update_en = 1'b0; flush_req = 1'b0; taken_update = 1'b0;
      pc_update = '0; target_addr_update = '0;
      query(32'h0000_1008, 1'b1);
      checks++; if (hit !== 1'b0) begin errors++; $display("FAIL reset_hit got %0b exp 0", hit); end
      checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL reset_pred got %0b exp 0", pred_taken); end
      checks++; if (target_addr !== 32'h0) begin errors++; $display("FAIL reset_tgt got %h exp 0", target_addr); end
      checks++; if (flush_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", flush_busy); end
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_alloc();
      do_update(32'h0000_1008, 32'h0000_2000, 1'b1);
      query(32'h0000_1008, 1'b1);
      checks++; if (hit !== 1'b1) begin errors++; $display("FAIL alloc_hit got %0b exp 1", hit); end
      checks++; if (target_addr !== 32'h2000) begin errors++; $display("FAIL alloc_tgt got %h exp 2000", target_addr); end
      checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL alloc_pred got %0b exp 1", pred_taken); end
      query(32'h0000_1008, 1'b0);
      checks++; if (hit !== 1'b0) begin errors++; $display("FAIL nojump_hit got %0b exp 0", hit); end
      checks++; if (target_addr !== 32'h0) begin errors++; $display("FAIL nojump_tgt got %h exp 0", target_addr); end
   endtask

   task automatic test_not_taken();
      do_update(32'h0000_3000, 32'h0000_4444, 1'b0);
      query(32'h0000_3000, 1'b1);
      checks++; if (hit !== 1'b0) begin errors++; $display("FAIL nt_miss_hit got %0b exp 0", hit); end
   endtask

   task automatic test_counter();
      // entry 0x1008 starts at 10
      do_update(32'h0000_1008, 32'h0000_2000, 1'b0);  // 01
      query(32'h0000_1008, 1'b1);
      checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL ctr_dec1 got %0b exp 0", pred_taken); end
      checks++; if (hit !== 1'b1) begin errors++; $display("FAIL ctr_dec1_hit got %0b exp 1", hit); end
      do_update(32'h0000_1008, 32'h0000_2000, 1'b0);  // 00
      do_update(32'h0000_1008, 32'h0000_2000, 1'b0);  // stays 00
      query(32'h0000_1008, 1'b1);
      checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL ctr_sat_lo got %0b exp 0", pred_taken); end
      do_update(32'h0000_1008, 32'h0000_2000, 1'b1);  // 01
      query(32'h0000_1008, 1'b1);
      checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL ctr_inc1 got %0b exp 0", pred_taken); end
      do_update(32'h0000_1008, 32'h0000_2000, 1'b1);  // 10
      query(32'h0000_1008, 1'b1);
      checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL ctr_inc2 got %0b exp 1", pred_taken); end
      do_update(32'h0000_1008, 32'h0000_2100, 1'b1);  // 11
      do_update(32'h0000_1008, 32'h0000_2200, 1'b1);  // stays 11
      do_update(32'h0000_1008, 32'h0000_2300, 1'b0);  // 10
      query(32'h0000_1008, 1'b1);
      checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL ctr_sat_hi got %0b exp 1", pred_taken); end
      checks++; if (target_addr !== 32'h2300) begin errors++; $display("FAIL ctr_tgt_rewrite got %h exp 2300", target_addr); end
   endtask

   task automatic test_replace();
      apply_reset();
      do_update(32'h0000_1008, 32'h0000_A000, 1'b1);  // way0
      do_update(32'h0010_1008, 32'h0000_B000, 1'b1);  // way1
      do_update(32'h0020_1008, 32'h0000_C000, 1'b1);  // evicts way0, ptr->1
      query(32'h0000_1008, 1'b1);
      checks++; if (hit !== 1'b0) begin errors++; $display("FAIL repl_evict0 got %0b exp 0", hit); end
      query(32'h0010_1008, 1'b1);
      checks++; if (hit !== 1'b1 || target_addr !== 32'hB000) begin errors++; $display("FAIL repl_keep1 got %0b/%h exp 1/b000", hit, target_addr); end
      query(32'h0020_1008, 1'b1);
      checks++; if (hit !== 1'b1 || target_addr !== 32'hC000) begin errors++; $display("FAIL repl_new got %0b/%h exp 1/c000", hit, target_addr); end
      do_update(32'h0030_1008, 32'h0000_D000, 1'b1);  // evicts way1
      query(32'h0010_1008, 1'b1);
      checks++; if (hit !== 1'b0) begin errors++; $display("FAIL repl_evict1 got %0b exp 0", hit); end
      query(32'h0020_1008, 1'b1);
      checks++; if (hit !== 1'b1 || target_addr !== 32'hC000) begin errors++; $display("FAIL repl_keep0 got %0b/%h exp 1/c000", hit, target_addr); end
      query(32'h0030_1008, 1'b1);
      checks++; if (hit !== 1'b1 || target_addr !== 32'hD000) begin errors++; $display("FAIL repl_new2 got %0b/%h exp 1/d000", hit, target_addr); end
   endtask

   task automatic test_flush();
      int n;
      apply_reset();
      do_update(32'h0000_4004, 32'h0000_8010, 1'b1);
      do_update(32'h0000_4008, 32'h0000_8020, 1'b1);
      do_update(32'h0000_400C, 32'h0000_8030, 1'b1);
      do_update(32'h0000_4050, 32'h0000_8040, 1'b1);
      query(32'h0000_4050, 1'b1);
      checks++; if (hit !== 1'b1) begin errors++; $display("FAIL flush_prefill got %0b exp 1", hit); end
      flush_req = 1'b1;
      update_en = 1'b1; pc_update = 32'h0000_507C; target_addr_update = 32'h9999; taken_update = 1'b1;
      @(posedge clk); #1;
      flush_req = 1'b0; update_en = 1'b0;
      checks++; if (flush_busy !== 1'b1) begin errors++; $display("FAIL flush_rise got %0b exp 1", flush_busy); end
      n = 0;
      while (flush_busy && n < 40) begin
         if (n == 3) begin
            update_en = 1'b1; pc_update = 32'h0000_6000; target_addr_update = 32'h7777; taken_update = 1'b1;
         end
         if (n == 4) update_en = 1'b0;
         if (n == 5) begin
            flush_req = 1'b1;
            query(32'h0000_4050, 1'b1);
            checks++; if (hit !== 1'b0) begin errors++; $display("FAIL flush_hit_gate got %0b exp 0", hit); end
         end
         if (n == 6) flush_req = 1'b0;
         n++;
         @(posedge clk); #1;
      end
      checks++; if (n != 32) begin errors++; $display("FAIL flush_len got %0d exp 32", n); end
      query(32'h0000_4004, 1'b1);
      checks++; if (hit !== 1'b0) begin errors++; $display("FAIL flush_clear_a got %0b exp 0", hit); end
      query(32'h0000_4050, 1'b1);
      checks++; if (hit !== 1'b0) begin errors++; $display("FAIL flush_clear_b got %0b exp 0", hit); end
      query(32'h0000_6000, 1'b1);
      checks++; if (hit !== 1'b0) begin errors++; $display("FAIL flush_upd_drop got %0b exp 0", hit); end
      query(32'h0000_507C, 1'b1);
      checks++; if (hit !== 1'b0) begin errors++; $display("FAIL flush_accept_drop got %0b exp 0", hit); end
      do_update(32'h0000_4008, 32'h0000_ABC0, 1'b1);
      query(32'h0000_4008, 1'b1);
      checks++; if (hit !== 1'b1 || target_addr !== 32'hABC0) begin errors++; $display("FAIL flush_realloc got %0b/%h exp 1/abc0", hit, target_addr); end
   endtask

   task automatic test_reset_mid_flush();
      int n;
      apply_reset();
      do_update(32'h0000_4050, 32'h0000_8040, 1'b1);
      flush_req = 1'b1;
      @(posedge clk); #1;
      flush_req = 1'b0;
      repeat (10) @(posedge clk);
      #3;
      query(32'h0000_4050, 1'b1);
      checks++; if (flush_busy !== 1'b1) begin errors++; $display("FAIL mid_busy_pre got %0b exp 1", flush_busy); end
      rst = 1'b1;
      #1;
      checks++; if (flush_busy !== 1'b0) begin errors++; $display("FAIL mid_busy_drop got %0b exp 0", flush_busy); end
      checks++; if (hit !== 1'b0) begin errors++; $display("FAIL mid_hit_drop got %0b exp 0", hit); end
      #2;
      rst = 1'b0;
      @(posedge clk); #1;
      query(32'h0000_4050, 1'b1);
      checks++; if (hit !== 1'b0) begin errors++; $display("FAIL mid_post_miss got %0b exp 0", hit); end
      flush_req = 1'b1;
      @(posedge clk); #1;
      flush_req = 1'b0;
      n = 0;
      while (flush_busy && n < 40) begin
         n++;
         @(posedge clk); #1;
      end
      checks++; if (n != 32) begin errors++; $display("FAIL mid_reflush_len got %0d exp 32", n); end
   endtask

   initial begin
      test_reset();
      test_alloc();
      test_not_taken();
      test_counter();
      test_replace();
      test_flush();
      test_reset_mid_flush();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
